// File: rtl/writeback_queue_if.sv
// Bundle of the writeback queue's request, register-file write and bypass signals.
// master = pipeline/upstream side, slave = the queue itself.
interface writeback_queue_if #(parameter int DEPTH = 4);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             alu_valid;
  logic [2:0]       alu_addr;
  logic [31:0]      alu_value;
  logic             id_valid;
  logic [2:0]       id_addr;
  logic [31:0]      id_value;
  logic             stall;

  logic             write_enable;
  logic [2:0]       write_addr;
  logic [31:0]      write_value_alu;
  logic [31:0]      write_value_id;
  logic             write_data_sel;
  logic [CNT_W-1:0] pending;

  logic [2:0]       fwd_addr1;
  logic [2:0]       fwd_addr2;
  logic             fwd_hit1;
  logic             fwd_hit2;
  logic [31:0]      fwd_val1;
  logic [31:0]      fwd_val2;

  modport master (
    output alu_valid, alu_addr, alu_value, id_valid, id_addr, id_value,
    output fwd_addr1, fwd_addr2,
    input  stall, write_enable, write_addr, write_value_alu, write_value_id,
    input  write_data_sel, pending, fwd_hit1, fwd_hit2, fwd_val1, fwd_val2
  );

  modport slave (
    input  alu_valid, alu_addr, alu_value, id_valid, id_addr, id_value,
    input  fwd_addr1, fwd_addr2,
    output stall, write_enable, write_addr, write_value_alu, write_value_id,
    output write_data_sel, pending, fwd_hit1, fwd_hit2, fwd_val1, fwd_val2
  );
endinterface

// File: rtl/writeback_queue.sv
// Writeback queue: ALU/ID write requests drain in order to the register file, one per cycle, one-cycle minimum latency.
// stall holds off new requests when fewer than two slots remain; WRITEBACK_QUEUE_BYPASS_EN adds the youngest-match bypass lookup.
module writeback_queue #(
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  writeback_queue_if.slave wq
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [2:0]  addr;
    logic [31:0] value;
    logic        src;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             accept;
  logic             deq;
  logic [1:0]       enq_num;
  entry_t           head;
  entry_t           alu_entry;
  entry_t           id_entry;

  // Stall leaves room for a worst-case dual enqueue, so the write side never checks for space.
  assign wq.stall  = (count >= CNT_W'(DEPTH - 1));
  assign accept    = !wq.stall;
  assign enq_num   = accept ? ({1'b0, wq.alu_valid} + {1'b0, wq.id_valid}) : 2'd0;
  assign deq       = (count != '0);
  assign count_nxt = count + CNT_W'(enq_num) - CNT_W'(deq);

  assign alu_entry = '{addr: wq.alu_addr, value: wq.alu_value, src: 1'b1};
  assign id_entry  = '{addr: wq.id_addr,  value: wq.id_value,  src: 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(deq);
      wr_ptr <= wr_ptr + PTR_W'(enq_num);
      count  <= count_nxt;
    end
  end

  // ALU lands first when both arrive, so it is the older of the pair.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      if (wq.alu_valid) mem[wr_ptr] <= alu_entry;
      if (wq.id_valid)  mem[wr_ptr + PTR_W'(wq.alu_valid)] <= id_entry;
    end
  end

  assign head = mem[rd_ptr];

  assign wq.pending         = count;
  assign wq.write_enable    = deq;
  assign wq.write_addr      = deq ? head.addr : 3'd0;
  assign wq.write_data_sel  = deq & head.src;
  assign wq.write_value_alu = (deq &&  head.src) ? head.value : 32'd0;
  assign wq.write_value_id  = (deq && !head.src) ? head.value : 32'd0;

`ifdef WRITEBACK_QUEUE_BYPASS_EN
  // Walk oldest to youngest so a later match overwrites an earlier one.
  always_comb begin
    wq.fwd_hit1 = 1'b0;
    wq.fwd_val1 = 32'd0;
    wq.fwd_hit2 = 1'b0;
    wq.fwd_val2 = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      automatic logic [PTR_W-1:0] idx = rd_ptr + PTR_W'(i);
      if (CNT_W'(i) < count) begin
        if (mem[idx].addr == wq.fwd_addr1) begin
          wq.fwd_hit1 = 1'b1;
          wq.fwd_val1 = mem[idx].value;
        end
        if (mem[idx].addr == wq.fwd_addr2) begin
          wq.fwd_hit2 = 1'b1;
          wq.fwd_val2 = mem[idx].value;
        end
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd  = ^{wq.fwd_addr1, wq.fwd_addr2};
  assign wq.fwd_hit1 = 1'b0;
  assign wq.fwd_hit2 = 1'b0;
  assign wq.fwd_val1 = 32'd0;
  assign wq.fwd_val2 = 32'd0;
`endif

  count_bounded: assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH));

endmodule
